// File: rtl/uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_bridge
// Function : Host-side 8N1 UART front end. Pairs received bytes into 16-bit
//            commands (high byte first) and serialises 8-bit responses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_bridge #(
  parameter int BAUD_DIV = 868,
  parameter int TMO_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int TW      = $clog2(BAUD_DIV);
  localparam int TMO_CYC = TMO_BITS * BAUD_DIV;
  localparam int MW      = $clog2(TMO_CYC);

  localparam logic [TW-1:0] BIT_LAST  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(BAUD_DIV / 2 - 1);
  localparam logic [MW-1:0] TMO_LAST  = MW'(TMO_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [0:0] {WAIT_HI, WAIT_LO} asm_state_t;

  logic            rx_meta, rx_sync;
  rx_state_t       rx_state;
  logic [TW-1:0]   rx_timer;
  logic [2:0]      rx_bits;
  logic [7:0]      rx_shift;
  logic            stop_sample, byte_done, stop_bad;

  asm_state_t      asm_state;
  logic [7:0]      hold_hi;
  logic [MW-1:0]   tmo_cnt;

  tx_state_t       tx_state;
  logic [TW-1:0]   tx_timer;
  logic [2:0]      tx_bits;
  logic [7:0]      tx_shift;

  // Two-flop synchroniser for the asynchronous RX line, preset to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling of start, eight data bits (LSB first) and stop
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_timer  <= '0;
      rx_bits   <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_timer <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_timer == HALF_LAST) begin
            rx_timer <= '0;
            rx_bits  <= '0;
            // A line back high at mid-start is a glitch, not a frame
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_timer == BIT_LAST) begin
            rx_timer <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
            else                 rx_bits  <= rx_bits + 1'b1;
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_timer == BIT_LAST) begin
            rx_timer  <= '0;
            frame_err <= ~rx_sync;
            rx_state  <= RX_IDLE;
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // The stop-bit sample cycle decides whether rx_shift is a valid byte
  assign stop_sample = (rx_state == RX_STOP) && (rx_timer == BIT_LAST);
  assign byte_done   = stop_sample &  rx_sync;
  assign stop_bad    = stop_sample & ~rx_sync;

  // Command assembler: pairs bytes, times out a lonely high byte, guards cmd while held
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state <= WAIT_HI;
      hold_hi   <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (clr_cmd_rdy && cmd_rdy) cmd_rdy <= 1'b0;
      if (stop_bad) begin
        asm_state <= WAIT_HI;
        hold_hi   <= '0;
      end else if (byte_done && cmd_rdy) begin
        // Consumer has not taken the previous command: drop this byte
        overrun <= 1'b1;
      end else if (byte_done) begin
        if (asm_state == WAIT_HI) begin
          hold_hi   <= rx_shift;
          tmo_cnt   <= '0;
          asm_state <= WAIT_LO;
        end else begin
          cmd       <= {hold_hi, rx_shift};
          cmd_rdy   <= 1'b1;
          asm_state <= WAIT_HI;
        end
      end else if (asm_state == WAIT_LO) begin
        if (tmo_cnt == TMO_LAST) begin
          asm_state <= WAIT_HI;
          hold_hi   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  // Transmit FSM: registered TX line, one start, eight data (LSB first), one stop
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_timer  <= '0;
      tx_bits   <= '0;
      tx_shift  <= '0;
      TX        <= 1'b1;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          tx_timer <= '0;
          if (send_resp) begin
            tx_shift <= resp;
            TX       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer <= '0;
            tx_bits  <= '0;
            TX       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer <= '0;
            if (tx_bits == 3'd7) begin
              TX       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              TX       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bits  <= tx_bits + 1'b1;
            end
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer  <= '0;
            resp_sent <= 1'b1;
            tx_busy   <= 1'b0;
            tx_state  <= TX_IDLE;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_bridge
// Function : Self-checking bench for uart_cmd_bridge (BAUD_DIV=16, TMO_BITS=20)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_bridge;

  localparam int BAUD = 16;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rst, RX, clr_cmd_rdy, send_resp;
  logic [7:0]  resp;
  logic        TX, cmd_rdy, resp_sent, tx_busy, frame_err, overrun;
  logic [15:0] cmd;

  int vectors = 0;
  int errors  = 0;

  uart_cmd_bridge #(.BAUD_DIV(BAUD), .TMO_BITS(TMO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Free-running cycle count and pulse/event monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          fe_cnt = 0, ov_cnt = 0, rise_cyc = -1, hold_viol = 0, stop_cyc = 0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_cmd = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (cmd_rdy && !prev_rdy) rise_cyc = cyc;
      if (cmd_rdy && prev_rdy && cmd !== prev_cmd) hold_viol++;
      prev_rdy = cmd_rdy;
      prev_cmd = cmd;
    end
  end

  // Host-side 8N1 byte, optionally with a bad stop bit
  task automatic host_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) stop_cyc = cyc;
      RX = fr[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_cmd();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // Leaves the bench at the negedge just after the accepting clock edge
  task automatic tx_start(input logic [7:0] b);
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  // Checks one response frame bit by bit; ends at the negedge where resp_sent is due
  task automatic tx_frame(input logic [7:0] b, input logic inject);
    logic [9:0] fr;
    logic       busy_ok;
    fr = {1'b1, b, 1'b0};
    busy_ok = 1'b1;
    for (int c = 0; c < 10 * BAUD; c++) begin
      if (c % BAUD == BAUD / 2) begin
        vectors++;
        if (TX !== fr[c / BAUD]) begin
          errors++;
          $display("FAIL tx_bit%0d: TX=%b expected %b (byte %h)", c / BAUD, TX, fr[c / BAUD], b);
        end
      end
      if (tx_busy !== 1'b1 || resp_sent !== 1'b0) busy_ok = 1'b0;
      if (inject && c == 39) begin resp = 8'h3C; send_resp = 1'b1; end
      if (inject && c == 40) send_resp = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (!busy_ok) begin errors++; $display("FAIL tx_busy_frame: busy/resp_sent wrong mid-frame (byte %h) expected busy=1 sent=0", b); end
    vectors++;
    if (resp_sent !== 1'b1) begin errors++; $display("FAIL resp_sent_pulse: got %b expected 1 at clk 160", resp_sent); end
    vectors++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end: got %b expected 0 with resp_sent", tx_busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (TX !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b expected 1", TX); end
    vectors++; if (cmd !== 16'h0)     begin errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
    vectors++; if (cmd_rdy !== 1'b0)  begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
    vectors++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    vectors++; if (resp_sent !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: sent/fe/ov=%b%b%b expected 000", resp_sent, frame_err, overrun);
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_cmd_basic();
    host_send(8'h08, 1'b1);
    host_send(8'hA5, 1'b1);
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1)  begin errors++; $display("FAIL basic_rdy: got %b expected 1", cmd_rdy); end
    vectors++; if (cmd !== 16'h08A5)  begin errors++; $display("FAIL basic_cmd: got %h expected 08a5", cmd); end
    vectors++;
    if (rise_cyc - stop_cyc < 9 || rise_cyc - stop_cyc > 15) begin
      errors++; $display("FAIL basic_latency: cmd_rdy rose %0d clk into stop bit, expected 9..15", rise_cyc - stop_cyc);
    end
    clear_cmd();
    vectors++; if (cmd_rdy !== 1'b0)  begin errors++; $display("FAIL basic_clear: got %b expected 0", cmd_rdy); end
  endtask

  task automatic test_tx();
    logic quiet;
    tx_start(8'hA5);
    tx_frame(8'hA5, 1'b1);
    @(negedge clk);
    vectors++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL tx_single_pulse: got %b expected 0", resp_sent); end
    quiet = 1'b1;
    repeat (40) begin
      if (TX !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    vectors++; if (!quiet) begin errors++; $display("FAIL tx_ignored_send: line active after frame, expected idle"); end
  endtask

  task automatic test_frame_err();
    int fe0;
    host_send(8'h12, 1'b1);
    @(posedge clk);
    fe0 = fe_cnt;
    host_send(8'h99, 1'b0);
    @(posedge clk);
    vectors++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
    vectors++; if (cmd_rdy !== 1'b0)   begin errors++; $display("FAIL ferr_no_cmd: cmd_rdy=%b expected 0", cmd_rdy); end
    host_send(8'h34, 1'b1);
    host_send(8'h56, 1'b1);
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1 || cmd !== 16'h3456) begin
      errors++; $display("FAIL ferr_resync: rdy=%b cmd=%h expected 1 3456", cmd_rdy, cmd);
    end
    clear_cmd();
  endtask

  task automatic test_timeout();
    host_send(8'h12, 1'b1);
    idle(400);
    host_send(8'h34, 1'b1);
    host_send(8'h56, 1'b1);
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1 || cmd !== 16'h3456) begin
      errors++; $display("FAIL tmo_drop: rdy=%b cmd=%h expected 1 3456", cmd_rdy, cmd);
    end
    clear_cmd();
    host_send(8'h12, 1'b1);
    idle(100);
    host_send(8'h34, 1'b1);
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1 || cmd !== 16'h1234) begin
      errors++; $display("FAIL tmo_within: rdy=%b cmd=%h expected 1 1234", cmd_rdy, cmd);
    end
    clear_cmd();
  endtask

  task automatic test_overrun();
    int ov0, fe0;
    host_send(8'h11, 1'b1);
    host_send(8'h22, 1'b1);
    @(posedge clk);
    ov0 = ov_cnt;
    host_send(8'h77, 1'b1);
    @(posedge clk);
    vectors++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulses expected 1", ov_cnt - ov0); end
    vectors++; if (cmd_rdy !== 1'b1 || cmd !== 16'h1122) begin
      errors++; $display("FAIL ovr_hold: rdy=%b cmd=%h expected 1 1122", cmd_rdy, cmd);
    end
    clear_cmd();
    fe0 = fe_cnt;
    @(negedge clk);
    RX = 1'b0;
    idle(8);
    RX = 1'b1;
    idle(200);
    vectors++; if (cmd_rdy !== 1'b0 || fe_cnt !== fe0) begin
      errors++; $display("FAIL glitch_quiet: rdy=%b ferr=%0d expected 0 0", cmd_rdy, fe_cnt - fe0);
    end
    host_send(8'hAB, 1'b1);
    host_send(8'hCD, 1'b1);
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1 || cmd !== 16'hABCD) begin
      errors++; $display("FAIL glitch_pair: rdy=%b cmd=%h expected 1 abcd", cmd_rdy, cmd);
    end
    clear_cmd();
  endtask

  // Random byte stream against a pairing model with frame errors and timeouts
  task automatic test_random_rx();
    logic        have_hi, stop_ok, exp_rdy, exp_fe;
    logic [7:0]  hi, b;
    logic [15:0] exp_cmd;
    int          gap, fe0;
    have_hi = 1'b0; hi = '0; exp_cmd = '0;
    for (int n = 0; n < 16; n++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 5) != 0);
      gap     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(360, 480)) : int'($urandom_range(12, 100));
      idle(gap);
      if (have_hi && (gap + 10 * BAUD > TMO * BAUD)) have_hi = 1'b0;
      exp_fe = 1'b0; exp_rdy = 1'b0;
      if (!stop_ok) begin
        exp_fe = 1'b1; have_hi = 1'b0;
      end else if (!have_hi) begin
        have_hi = 1'b1; hi = b;
      end else begin
        exp_cmd = {hi, b}; exp_rdy = 1'b1; have_hi = 1'b0;
      end
      @(posedge clk);
      fe0 = fe_cnt;
      host_send(b, stop_ok);
      @(posedge clk);
      vectors++; if ((fe_cnt - fe0) !== int'(exp_fe)) begin
        errors++; $display("FAIL rnd%0d_ferr: got %0d expected %0d", n, fe_cnt - fe0, exp_fe);
      end
      vectors++; if (cmd_rdy !== exp_rdy) begin
        errors++; $display("FAIL rnd%0d_rdy: got %b expected %b", n, cmd_rdy, exp_rdy);
      end
      if (exp_rdy) begin
        vectors++; if (cmd !== exp_cmd) begin
          errors++; $display("FAIL rnd%0d_cmd: got %h expected %h", n, cmd, exp_cmd);
        end
      end
      if (cmd_rdy) clear_cmd();
    end
    if (have_hi) idle(400);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    tx_start(b);
    for (int k = 0; k < 3; k++) begin
      tx_frame(b, 1'b0);
      if (k < 2) begin
        b = 8'($urandom_range(0, 255));
        resp = b;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
      end
    end
    idle(4);
  endtask

  task automatic test_simultaneous();
    logic [7:0] tb_b;
    tb_b = 8'($urandom_range(0, 255));
    fork
      begin host_send(8'hC0, 1'b1); host_send(8'hDE, 1'b1); end
      begin tx_start(tb_b); tx_frame(tb_b, 1'b0); end
    join
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1 || cmd !== 16'hC0DE) begin
      errors++; $display("FAIL sim_cmd: rdy=%b cmd=%h expected 1 c0de", cmd_rdy, cmd);
    end
    clear_cmd();
  endtask

  task automatic test_reset_mid();
    host_send(8'h44, 1'b1);
    host_send(8'h55, 1'b1);
    tx_start(8'h00);
    RX = 1'b0;
    idle(50);
    vectors++; if (TX !== 1'b0 || tx_busy !== 1'b1 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: TX=%b busy=%b rdy=%b expected 0 1 1", TX, tx_busy, cmd_rdy);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (TX !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_tx: TX=%b busy=%b expected 1 0", TX, tx_busy);
    end
    vectors++; if (cmd_rdy !== 1'b0 || cmd !== 16'h0) begin
      errors++; $display("FAIL rstmid_cmd: rdy=%b cmd=%h expected 0 0000", cmd_rdy, cmd);
    end
    RX = 1'b1;
    rst = 1'b0;
    idle(20);
    host_send(8'h3C, 1'b1);
    host_send(8'hC3, 1'b1);
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1 || cmd !== 16'h3CC3) begin
      errors++; $display("FAIL rstmid_pair: rdy=%b cmd=%h expected 1 3cc3", cmd_rdy, cmd);
    end
    clear_cmd();
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_tx();
    test_frame_err();
    test_timeout();
    test_overrun();
    test_random_rx();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    vectors++; if (hold_viol !== 0) begin
      errors++; $display("FAIL cmd_stable: cmd changed %0d times while cmd_rdy held, expected 0", hold_viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
